// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers.
package pipe_pkg;

  // Control vector bit positions
  localparam int unsigned CTRL_MEMW = 0;
  localparam int unsigned CTRL_M2R  = 1;
  localparam int unsigned CTRL_REGW = 2;
  localparam int unsigned CTRL_MEM  = 3;
  localparam int unsigned CTRL_WORD = 4;
  localparam int unsigned CTRL_HALT = 5;

  localparam int unsigned CTRL_W_DEF = 6;

  // Side-effecting control bits that must read as 0 on a bubble
  localparam logic [CTRL_W_DEF-1:0] KILL_MASK_DEF = 6'b000111;

  // Occupancy: nothing held, main slot only, main + skid slots
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Single payload register with load enable; used for the main and skid slots.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture payload when loaded, clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic EX->MEM style pipeline register with valid/ready handshake,
// optional skid slot, flush, bubble masking, halt tracking and forwarding tap.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          CTRL_W    = CTRL_W_DEF,
  parameter int unsigned          RD_W      = 5,
  parameter int unsigned          SKID      = 1,
  parameter logic [CTRL_W-1:0]    KILL_MASK = CTRL_W'(KILL_MASK_DEF),
  parameter int unsigned          REGW_BIT  = CTRL_REGW,
  parameter int unsigned          HALT_BIT  = CTRL_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_rs2,
  output logic [RD_W-1:0]   out_rd,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted
);

  localparam int unsigned PW = CTRL_W + 2 * DATA_W + RD_W;

  pipe_state_e       state_q, state_d;
  logic              halt_pending_q, halt_pending_d;
  logic              halted_q, halted_d;
  logic              main_ld, skid_ld, sel_skid;
  logic              accept, acc_eff, retire;
  logic [PW-1:0]     in_pl, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_pl     = {in_ctrl, in_alu, in_rs2, in_rd};
  assign main_ctrl = main_q[PW-1 -: CTRL_W];

  assign out_valid = (state_q != ST_EMPTY);
  assign out_alu   = main_q[RD_W+DATA_W +: DATA_W];
  assign out_rs2   = main_q[RD_W +: DATA_W];
  assign out_rd    = main_q[RD_W-1:0];
  assign out_ctrl  = out_valid ? main_ctrl : (main_ctrl & ~KILL_MASK);
  assign fwd_valid = out_valid & main_ctrl[REGW_BIT] & (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_alu;
  assign halted    = halted_q;

  // Upstream readiness: registered-state only with a skid slot, pass-through otherwise
  generate
    if (SKID != 0) begin : g_rdy_skid
      assign in_ready = !rst && (state_q != ST_SKID) && !halt_pending_q && !halted_q;
    end else begin : g_rdy_single
      assign in_ready = !rst && (out_ready || !out_valid) && !halt_pending_q && !halted_q;
    end
  endgenerate

  assign accept  = in_valid & in_ready;
  assign acc_eff = accept & !flush;
  assign retire  = out_valid & out_ready;

  assign main_d = sel_skid ? skid_q : in_pl;

  pipe_slot #(.W(PW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_ld),
    .d    (main_d),
    .q    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.W(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_ld),
        .d    (in_pl),
        .q    (skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate

  // State, halt-pending and sticky halted registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
    end
  end

  // Occupancy transitions, slot load steering and halt bookkeeping
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    sel_skid       = 1'b0;
    halt_pending_d = halt_pending_q;
    halted_d       = halted_q;

    case (state_q)
      ST_EMPTY: begin
        if (acc_eff) begin
          state_d = ST_FULL;
          main_ld = 1'b1;
        end
      end
      ST_FULL: begin
        if (acc_eff && out_ready) begin
          main_ld = 1'b1;
        end else if (acc_eff) begin
          state_d = ST_SKID;
          skid_ld = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready && !flush) begin
          state_d  = ST_FULL;
          main_ld  = 1'b1;
          sel_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // The halt entry is always the youngest, so its retire is the head's retire
    if (retire && main_ctrl[HALT_BIT]) begin
      halt_pending_d = 1'b0;
      halted_d       = 1'b1;
    end
    if (acc_eff && in_ctrl[HALT_BIT]) begin
      halt_pending_d = 1'b1;
    end

    // Squash wins over everything except a retire already in flight
    if (flush) begin
      state_d        = ST_EMPTY;
      halt_pending_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO-queue reference model plus directed literals.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_ctrl = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_ctrl;
  logic [31:0] out_alu;
  logic [31:0] out_rs2;
  logic [4:0]  out_rd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        halted;

  int checks = 0;
  int passed = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_alu    (in_alu),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_alu   (out_alu),
    .out_rs2   (out_rs2),
    .out_rd    (out_rd),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] a;
    logic [31:0] s;
    logic [4:0]  r;
  } ent_t;

  // Reference model: a 2-deep queue, last head seen, halt flags
  ent_t q[$];
  ent_t last_head = '0;
  bit   m_hp = 1'b0;
  bit   m_halted = 1'b0;
  bit   last_hs = 1'b0;

  function automatic bit m_ready();
    return !rst && (q.size() < 2) && !m_hp && !m_halted;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Advance the model on each edge (or immediately on reset)
  always @(posedge clk or posedge rst) begin : model
    bit acc, ret;
    if (rst) begin
      q.delete();
      last_head = '0;
      m_hp      = 1'b0;
      m_halted  = 1'b0;
      last_hs   = 1'b0;
    end else begin
      acc = in_valid && m_ready();
      ret = (q.size() > 0) && out_ready;
      if (ret && q[0].c[5]) begin
        m_halted = 1'b1;
        m_hp     = 1'b0;
      end
      if (flush) begin
        q.delete();
        m_hp = 1'b0;
      end else begin
        if (ret) void'(q.pop_front());
        if (acc) begin
          q.push_back('{c: in_ctrl, a: in_alu, s: in_rs2, r: in_rd});
          if (in_ctrl[5]) m_hp = 1'b1;
        end
      end
      if (q.size() > 0) last_head = q[0];
      last_hs = acc;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin : compare
    ent_t h;
    bit   v;
    logic [5:0] ec;
    v  = (q.size() > 0);
    h  = v ? q[0] : last_head;
    ec = v ? h.c : (h.c & ~6'b000111);
    chk("in_ready",  {31'd0, in_ready},  {31'd0, m_ready()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, v});
    chk("out_ctrl",  {26'd0, out_ctrl},  {26'd0, ec});
    chk("out_alu",   out_alu,  h.a);
    chk("out_rs2",   out_rs2,  h.s);
    chk("out_rd",    {27'd0, out_rd},    {27'd0, h.r});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, v && h.c[2] && (h.r != 5'd0)});
    chk("fwd_rd",    {27'd0, fwd_rd},    {27'd0, h.r});
    chk("fwd_data",  fwd_data, h.a);
    chk("halted",    {31'd0, halted},    {31'd0, m_halted});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [5:0] c, input logic [31:0] a,
                       input logic [4:0] r, input bit ordy);
    in_valid  = iv;
    in_ctrl   = c;
    in_alu    = a;
    in_rs2    = ~a;
    in_rd     = r;
    out_ready = ordy;
  endtask

  logic [31:0] cnt;
  bit          cur_iv;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_alu",   out_alu, 32'd0);

    // Back-to-back with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'b000100, 32'(i), 5'd1, 1'b1);
      tick();
      chk("b2b_alu",   out_alu, 32'(i));
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    tick();

    // Backpressure into the skid slot, then drain in order
    drive(1'b1, 6'b000100, 32'h10, 5'd3, 1'b0);
    tick();
    drive(1'b1, 6'b000100, 32'h20, 5'd4, 1'b0);
    tick();
    chk("bp_in_ready_skid", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", out_alu, 32'h10);
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    tick();
    chk("bp_head_b", out_alu, 32'h20);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush while full of two entries with a new entry offered
    drive(1'b1, 6'b000111, 32'h11, 5'd5, 1'b0);
    tick();
    drive(1'b1, 6'b000111, 32'h22, 5'd6, 1'b0);
    tick();
    drive(1'b1, 6'b000111, 32'h30, 5'd7, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready",  {31'd0, in_ready},  32'd1);
    chk("fl_ctrl_mask", {29'd0, out_ctrl[2:0]}, 32'd0);
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    tick();
    chk("fl_no_c", {31'd0, out_valid}, 32'd0);
    chk("fl_hold_alu", out_alu, 32'h11);

    // Forwarding tap: rd=0 suppressed, rd=7 forwarded
    drive(1'b1, 6'b000100, 32'h55, 5'd0, 1'b1);
    tick();
    chk("fwd_rd0_valid", {31'd0, fwd_valid}, 32'd0);
    drive(1'b1, 6'b000100, 32'hDEAD, 5'd7, 1'b1);
    tick();
    chk("fwd_valid_rd7", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_rd_rd7",    {27'd0, fwd_rd},    32'd7);
    chk("fwd_data_rd7",  fwd_data, 32'hDEAD);
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    tick();

    // Mixed traffic with patterned stalls and one flush; upstream holds until accepted
    cnt    = 32'h100;
    cur_iv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!cur_iv || last_hs) begin
        if (last_hs) cnt = cnt + 32'd1;
        cur_iv = (i % 4) != 3;
      end
      drive(cur_iv, 6'(cnt[4:0]), cnt, cnt[4:0], (i % 3) != 0);
      flush = (i == 25);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    repeat (3) tick();

    // Asynchronous reset between edges while two entries are held
    drive(1'b1, 6'b000111, 32'h77, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'b000111, 32'h88, 5'd9, 1'b0);
    tick();
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_halted",    {31'd0, halted},    32'd0);
    chk("arst_out_ctrl",  {26'd0, out_ctrl},  32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 6'b000100, 32'h99, 5'd2, 1'b1);
    tick();
    chk("arst_first_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_first_alu",   out_alu, 32'h99);
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b1);
    tick();

    // Halt entry: stalls upstream, sets sticky halted on retire
    drive(1'b1, 6'b100000, 32'hAA, 5'd0, 1'b0);
    tick();
    chk("halt_pend_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 6'b0, 32'd0, 5'd0, 1'b0);
    tick();
    chk("halt_not_yet", {31'd0, halted}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("halt_set",       {31'd0, halted},   32'd1);
    chk("halt_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) tick();
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("halt_cleared", {31'd0, halted},   32'd0);
    chk("halt_ready",   {31'd0, in_ready}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
